// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
// Grants only on an idle line, strobes one byte, then waits for the frame or a timeout.
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int BUSY_TMO = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ-1:0]         req_par_en,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         err,
  output logic [DW-1:0]           tx_data,
  output logic                    tx_data_valid,
  output logic                    tx_parity_en,
  input  logic                    tx_busy,
  output logic                    arb_busy,
  output logic [$clog2(NREQ)-1:0] last_grant
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BUSY_TMO + 2);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   g_q, g_d;
  logic [IW-1:0]   lg_q, lg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [NREQ-1:0] err_q, err_d;
  logic [DW-1:0]   data_q, data_d;
  logic            par_q, par_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   win, idx;
  logic            found;

  // Rotating search: first pending requester after the last one served.
  always_comb begin
    win   = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    lg_d    = lg_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    par_d   = par_q;
    ack_d   = '0;
    err_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (found && !tx_busy) begin
          g_d     = win;
          data_d  = req_data[win*DW +: DW];
          par_d   = req_par_en[win];
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          ack_d[g_q] = 1'b1;
          lg_d       = g_q;
          state_d    = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TMO)) begin
          err_d[g_q] = 1'b1;
          ptr_d      = g_q;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          ptr_d   = g_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Strobe and busy flag follow the next state so they stay registered.
    valid_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= IW'(NREQ - 1);
      g_q     <= '0;
      lg_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      lg_q    <= lg_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
      par_q   <= par_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign ack           = ack_q;
  assign err           = err_q;
  assign tx_data       = data_q;
  assign tx_data_valid = valid_q;
  assign tx_parity_en  = par_q;
  assign arb_busy      = busy_q;
  assign last_grant    = lg_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: transaction-level grant-order model,
// behavioural transmitter and requesters, monitor checks strobes and responses.
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int TMO  = 15;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    logic          par;
    bit            is_err;
    int            d;
    int            f;
    int            at;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_par_en = '0;
  logic [NREQ-1:0]      ack, err;
  logic [DW-1:0]        tx_data;
  logic                 tx_data_valid, tx_parity_en, tx_busy, arb_busy;
  logic [1:0]           last_grant;

  logic tb_busy = 1'b0;
  logic ext_busy = 1'b0;
  logic mon_en = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   gen_issue[NREQ];
  int   gen_done[NREQ];
  int   grant_gen[NREQ];
  exp_t exp_q[$];
  exp_t cur, em;
  bit   in_flight = 1'b0;
  int   strobe_cyc = 0;
  int   follow_at = 0;
  int   t_rise = -1;
  int   t_fall = -1;
  int   mptr = NREQ - 1;
  logic [DW-1:0]   dat[NREQ];
  logic [NREQ-1:0] ea, ee;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .BUSY_TMO(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .req_par_en    (req_par_en),
    .ack           (ack),
    .err           (err),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_parity_en  (tx_parity_en),
    .tx_busy       (tx_busy),
    .arb_busy      (arb_busy),
    .last_grant    (last_grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign tx_busy = tb_busy | ext_busy;

  always_comb begin
    req = '0;
    for (int i = 0; i < NREQ; i++) req[i] = (gen_issue[i] != gen_done[i]);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  endtask

  function automatic int next_winner(input logic [NREQ-1:0] m, input int p);
    for (int i = 1; i <= NREQ; i++)
      if (m[(p + i) % NREQ]) return (p + i) % NREQ;
    return -1;
  endfunction

  function automatic bit all_done();
    for (int i = 0; i < NREQ; i++)
      if (gen_issue[i] != gen_done[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor, behavioural transmitter and requester drop-out.
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      tb_busy   = 1'b0;
      t_rise    = -1;
      t_fall    = -1;
      in_flight = 1'b0;
    end else begin
      if (tx_data_valid) begin
        if (in_flight) fail("double_strobe");
        if (exp_q.size() == 0) begin
          fail("unexpected_strobe");
        end else begin
          em = exp_q.pop_front();
          check("strobe_cycle", cyc, (em.at >= 0) ? em.at : follow_at);
          check("tx_data", tx_data, em.data);
          check("tx_parity_en", tx_parity_en, em.par);
          check("arb_busy", arb_busy, 1);
          cur        = em;
          in_flight  = 1'b1;
          strobe_cyc = cyc;
          grant_gen[em.idx] = gen_issue[em.idx];
          t_rise = em.is_err ? -1 : cyc + em.d;
          t_fall = em.is_err ? -1 : cyc + em.d + em.f;
        end
      end
      if ((ack | err) != '0) begin
        if (!in_flight) begin
          fail("unexpected_resp");
        end else begin
          ea = '0;
          ee = '0;
          if (cur.is_err) ee[cur.idx] = 1'b1;
          else ea[cur.idx] = 1'b1;
          check("ack", ack, ea);
          check("err", err, ee);
          check("resp_delay", cyc - strobe_cyc, cur.is_err ? TMO + 2 : cur.d + 1);
          check("tx_data_hold", tx_data, cur.data);
          check("tx_par_hold", tx_parity_en, cur.par);
          if (!cur.is_err) check("last_grant", last_grant, cur.idx);
          gen_done[cur.idx] = gen_issue[cur.idx];
          follow_at = cur.is_err ? cyc + 1 : strobe_cyc + cur.d + cur.f + 2;
          in_flight = 1'b0;
        end
      end
      tb_busy = (t_rise >= 0) && (cyc >= t_rise) && (cyc < t_fall);
    end
  end

  // Grant order from the rotating-priority rule, one record per transaction.
  task automatic push_expect(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] par,
                             input logic [NREQ-1:0] tmo, input int d, input int f,
                             input int at_first);
    int p;
    int w;
    logic [NREQ-1:0] m;
    exp_t e;
    bit first;
    p = mptr;
    m = mask;
    first = 1'b1;
    while (m != '0) begin
      w = next_winner(m, p);
      e.idx    = w;
      e.data   = dat[w];
      e.par    = par[w];
      e.is_err = tmo[w];
      e.d      = (d > 0) ? d : int'($urandom_range(1, 3));
      e.f      = (f > 0) ? f : int'($urandom_range(1, 6));
      e.at     = first ? at_first : -1;
      first    = 1'b0;
      exp_q.push_back(e);
      m[w] = 1'b0;
      p = w;
    end
    mptr = p;
  endtask

  task automatic drive(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] par);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        req_data[i*DW +: DW] = dat[i];
        req_par_en[i] = par[i];
        gen_issue[i]++;
      end
    end
  endtask

  task automatic wait_quiet();
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (gen_issue[i] != 0 && grant_gen[i] == gen_issue[i])
          req_data[i*DW +: DW] = DW'($urandom);
      if (exp_q.size() == 0 && !in_flight && !arb_busy && !tx_busy && all_done()) break;
      t++;
      if (t > 3000) begin
        fail("quiet_timeout");
        finish_sim();
      end
    end
  endtask

  task automatic run_batch(input logic [NREQ-1:0] mask, input logic [NREQ-1:0] par,
                           input logic [NREQ-1:0] tmo, input int d, input int f,
                           input int hold);
    wait_quiet();
    if (hold > 0) ext_busy = 1'b1;
    push_expect(mask, par, tmo, d, f, cyc + 1 + hold);
    drive(mask, par);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      ext_busy = 1'b0;
    end
  endtask

  task automatic rand_dat();
    for (int i = 0; i < NREQ; i++) dat[i] = DW'($urandom);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ack"}, ack, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_tx_valid"}, tx_data_valid, 0);
    check({tag, "_tx_par"}, tx_parity_en, 0);
    check({tag, "_arb_busy"}, arb_busy, 0);
    check({tag, "_last_grant"}, last_grant, 0);
  endtask

  initial begin
    logic [NREQ-1:0] rm, rp, rt;
    int t;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    mon_en = 1'b1;

    rand_dat();
    dat[1] = 8'hA5;
    run_batch(4'b1010, 4'b0000, 4'b0000, 2, 4, 0);
    rand_dat();
    run_batch(4'b1111, 4'b0000, 4'b0000, 1, 3, 0);
    run_batch(4'b1111, 4'b1010, 4'b0000, 1, 3, 0);
    rand_dat();
    run_batch(4'b0011, 4'b0000, 4'b0001, 2, 3, 0);
    rand_dat();
    run_batch(4'b0001, 4'b0000, 4'b0000, 1, 2, 5);
    rand_dat();
    run_batch(4'b0100, 4'b0100, 4'b0000, 3, 6, 0);

    run_batch(4'b0001, 4'b0000, 4'b0000, 1, 2, 0);
    wait_quiet();
    rand_dat();
    push_expect(4'b0111, 4'b0000, 4'b0000, 2, 20, cyc + 1);
    drive(4'b0111, 4'b0000);
    t = 0;
    while (!ack[1]) begin
      @(negedge clk);
      t++;
      if (t > 100) begin
        fail("ack1_timeout");
        finish_sim();
      end
    end
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    exp_q.delete();
    mptr = NREQ - 1;
    push_expect(4'b0101, 4'b0000, 4'b0000, 1, 3, cyc + 2);
    @(negedge clk);
    check("midrst_ack2", ack, 0);
    check("midrst_err2", err, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    repeat (40) begin
      rand_dat();
      rm = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      rp = NREQ'($urandom);
      rt = '0;
      for (int i = 0; i < NREQ; i++) rt[i] = ($urandom_range(0, 4) == 0);
      run_batch(rm, rp, rt, 0, 0, 0);
    end
    wait_quiet();
    finish_sim();
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DW, default 8, data byte width.
REQ-003 Parameter BUSY_TMO, default 15, max cycles to wait for tx_busy to rise after tx_data_valid.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req  in  NREQ  requester i has a byte pending; held until ack[i] or err[i].
REQ-007 req_data  in  NREQ*DW  byte of requester i at bits [i*DW +: DW].
REQ-008 req_par_en  in  NREQ  parity enable for requester i's byte.
REQ-009 ack  out  NREQ  one-cycle pulse: byte of requester i accepted by the transmitter.
REQ-010 err  out  NREQ  one-cycle pulse: byte of requester i aborted on timeout.
REQ-011 tx_data  out  DW  byte to transmitter.
REQ-012 tx_data_valid  out  1  one-cycle start strobe to transmitter.
REQ-013 tx_parity_en  out  1  parity enable to transmitter.
REQ-014 tx_busy  in  1  transmitter busy (high start..stop).
REQ-015 arb_busy  out  1  high in any state other than IDLE.
REQ-016 last_grant  out  clog2(NREQ)  index of most recently acked requester.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if |req and !tx_busy, winner = first set req index searching from ptr+1 upward, wrapping mod NREQ; latch req_data slice to tx_data, req_par_en bit to tx_parity_en, winner to g; go LOAD.
REQ-020 IDLE with tx_busy high SHALL NOT grant, regardless of req.
REQ-021 LOAD: tx_data_valid = 1 for exactly this one cycle; go WAIT_BUSY; timeout counter cleared to 0.
REQ-022 WAIT_BUSY: tx_busy = 1 -> ack[g] pulse next cycle, last_grant <= g, go WAIT_DONE.
REQ-023 WAIT_BUSY: tx_busy = 0 -> counter increments; counter == BUSY_TMO -> err[g] pulse, ptr <= g, go IDLE.
REQ-024 WAIT_DONE: tx_busy = 0 -> ptr <= g, go IDLE; else stay.
REQ-025 tx_data and tx_parity_en SHALL hold stable from LOAD until return to IDLE; req_data changes after grant are ignored.
REQ-026 Latency: req sampled in IDLE at edge N -> tx_data_valid high in cycle N+1; at most one tx_data_valid per transaction.
REQ-027 At most one bit of ack|err SHALL be high in any cycle; never both ack and err for one transaction.
REQ-028 Requester deasserting req after grant SHALL NOT cancel the transaction.
REQ-029 Counter width SHALL hold BUSY_TMO without wrap.
REQ-030 Back-to-back: next grant evaluated in the IDLE cycle after WAIT_DONE exit; min gap between tx_data_valid pulses = transmitter frame + 2 cycles.

Reset
REQ-031 rst = 1 at a clock edge SHALL force: state IDLE, ptr = NREQ-1 (requester 0 highest priority first), counter 0, last_grant 0, ack 0, err 0, tx_data 0, tx_data_valid 0, tx_parity_en 0, arb_busy 0.
REQ-032 rst mid-transaction SHALL abort with no ack/err pulse; pending requester re-arbitrated after release.

Verification
REQ-033 After reset, req = 4'b1010, req_data[15:8] = 8'hA5, model raises tx_busy 2 cycles after strobe -> tx_data = 8'hA5, one tx_data_valid, ack = 4'b0010, last_grant = 1.
REQ-034 req = 4'b1111 held continuously, four frames -> grant order 0,1,2,3, then 0 again; each ack one cycle wide.
REQ-035 tx_busy never rises after strobe -> err[g] high exactly 16 cycles after WAIT_BUSY entry (BUSY_TMO = 15), no ack, arbiter back in IDLE, next requester served.
REQ-036 tx_busy held high externally while req = 4'b0001 -> no tx_data_valid until tx_busy falls, then strobe next cycle.
REQ-037 rst asserted during WAIT_DONE -> all outputs at reset values next cycle, no ack/err; after release, req 0 re-granted first.
REQ-038 req_par_en = 4'b0100, req = 4'b0100, req_data slice changed after grant -> tx_parity_en = 1, tx_data keeps granted value through frame.
